// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage is the master: it issues req/addr and receives rdata/valid.
interface fetch_stage_if #(
  parameter int DATA_W = 16
);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, one-entry hold buffer
// for words returned under stall, branch redirect with in-flight discard, halt.
module fetch_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_taken,
  input  logic [DATA_W-1:0] br_target,
  fetch_stage_if.master     imem,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc_inc,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] pc,
  output logic              hlt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state;
  logic              discard;
  logic [DATA_W-1:0] holdBuf;

  logic              loadEn;
  logic [DATA_W-1:0] loadWord;
  logic              loadHalts;

  function automatic logic [DATA_W-1:0] pcInc(input logic [DATA_W-1:0] a);
    return a + DATA_W'(2);
  endfunction

  function automatic logic isHalt(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: 4] == 4'hF;
  endfunction

  // Which word (if any) is delivered to decode this cycle; branch wins over all.
  always_comb begin
    loadEn   = 1'b0;
    loadWord = imem.imem_rdata;
    case (state)
      WAIT: loadEn = imem.imem_valid && !discard && !br_taken && !stall;
      HOLD: begin
        loadEn   = !br_taken && !stall;
        loadWord = holdBuf;
      end
      default: loadEn = 1'b0;
    endcase
  end

  assign loadHalts = isHalt(loadWord);

  // Request is suppressed combinationally so a redirect never fetches a stale pc.
  assign imem.imem_req  = !rst && (state == FETCH) && !br_taken;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= '0;
      discard      <= 1'b0;
      holdBuf      <= '0;
      hlt          <= 1'b0;
      if_id_valid  <= 1'b0;
      if_id_instr  <= '0;
      if_id_pc_inc <= '0;
    end else begin
      // IF/ID register: flush beats a load, stall without load simply holds.
      if (flush) begin
        if_id_valid <= 1'b0;
      end else if (loadEn) begin
        if_id_instr  <= loadWord;
        if_id_pc_inc <= pcInc(pc);
        if_id_valid  <= 1'b1;
      end

      case (state)
        FETCH: begin
          if (br_taken) begin
            pc <= br_target;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (imem.imem_valid) begin
            if (discard || br_taken) begin
              discard <= 1'b0;
              if (br_taken) begin
                pc <= br_target;
              end
              state <= FETCH;
            end else if (stall) begin
              holdBuf <= imem.imem_rdata;
              state   <= HOLD;
            end else begin
              pc    <= pcInc(pc);
              hlt   <= loadHalts;
              state <= loadHalts ? HALTED : FETCH;
            end
          end else if (br_taken) begin
            // Word still in flight belongs to the old path; drop it on arrival.
            discard <= 1'b1;
            pc      <= br_target;
          end
        end

        HOLD: begin
          if (br_taken) begin
            pc    <= br_target;
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pcInc(pc);
            hlt   <= loadHalts;
            state <= loadHalts ? HALTED : FETCH;
          end
        end

        HALTED: begin
          if (br_taken) begin
            hlt   <= 1'b0;
            pc    <= br_target;
            state <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios followed by a randomized run, all checked against a
// cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, brTaken;
  logic [15:0] brTarget;
  logic [15:0] ifIdInstr, ifIdPcInc, pc;
  logic        ifIdValid, hlt;

  fetch_stage_if #(.DATA_W(16)) imemBus ();

  fetch_stage #(.DATA_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .br_taken     (brTaken),
    .br_target    (brTarget),
    .imem         (imemBus),
    .if_id_instr  (ifIdInstr),
    .if_id_pc_inc (ifIdPcInc),
    .if_id_valid  (ifIdValid),
    .pc           (pc),
    .hlt          (hlt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain flags describing what the fetch unit is doing.
  logic [15:0] mPc, mInstr, mPcInc, mBuf;
  logic        mValid, mHlt, mWaiting, mDiscard, mHeld;

  logic        seenReq;
  logic [15:0] seenAddr;

  // Random-phase stimulus variables.
  int          pend;
  logic        rR, rS, rF, rB, rV;
  logic [15:0] rT, rD;

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic deliver(input logic [15:0] w);
    if (!flush) begin
      mInstr = w;
      mPcInc = mPc + 16'd2;
      mValid = 1'b1;
    end
    mPc = mPc + 16'd2;
    if (w[15:12] == 4'hF) mHlt = 1'b1;
  endtask

  task automatic modelStep();
    if (rst) begin
      mPc = 16'h0; mInstr = 16'h0; mPcInc = 16'h0; mBuf = 16'h0;
      mValid = 1'b0; mHlt = 1'b0; mWaiting = 1'b0; mDiscard = 1'b0; mHeld = 1'b0;
      return;
    end
    if (mHlt) begin
      if (brTaken) begin
        mHlt = 1'b0;
        mPc  = brTarget;
      end
    end else if (mHeld) begin
      if (brTaken) begin
        mHeld = 1'b0;
        mPc   = brTarget;
      end else if (!stall) begin
        mHeld = 1'b0;
        deliver(mBuf);
      end
    end else if (mWaiting) begin
      if (imemBus.imem_valid) begin
        mWaiting = 1'b0;
        if (mDiscard || brTaken) begin
          mDiscard = 1'b0;
          if (brTaken) mPc = brTarget;
        end else if (stall) begin
          mBuf  = imemBus.imem_rdata;
          mHeld = 1'b1;
        end else begin
          deliver(imemBus.imem_rdata);
        end
      end else if (brTaken) begin
        mDiscard = 1'b1;
        mPc      = brTarget;
      end
    end else begin
      if (brTaken) mPc = brTarget;
      else         mWaiting = 1'b1;
    end
    if (flush) mValid = 1'b0;
  endtask

  // One clock: apply inputs after the falling edge, check the request path,
  // then check registered state just after the rising edge.
  task automatic tick(input logic r, input logic s, input logic f, input logic b,
                      input logic [15:0] t, input logic v, input logic [15:0] d);
    logic expReq;
    rst = r; stall = s; flush = f; brTaken = b; brTarget = t;
    imemBus.imem_valid = v; imemBus.imem_rdata = d;
    #1;
    seenReq  = imemBus.imem_req;
    seenAddr = imemBus.imem_addr;
    expReq   = !rst && !mWaiting && !mHeld && !mHlt && !brTaken;
    chk1("model_req", seenReq, expReq);
    chk16("model_addr", seenAddr, mPc);
    modelStep();
    @(posedge clk);
    #1;
    chk16("model_pc", pc, mPc);
    chk16("model_instr", ifIdInstr, mInstr);
    chk16("model_pcinc", ifIdPcInc, mPcInc);
    chk1("model_valid", ifIdValid, mValid);
    chk1("model_hlt", hlt, mHlt);
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic ret(input logic [15:0] w);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, w);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; brTaken = 1'b0; brTarget = 16'h0;
    imemBus.imem_valid = 1'b0; imemBus.imem_rdata = 16'h0;
    mPc = 16'h0; mInstr = 16'h0; mPcInc = 16'h0; mBuf = 16'h0;
    mValid = 1'b0; mHlt = 1'b0; mWaiting = 1'b0; mDiscard = 1'b0; mHeld = 1'b0;
    pend = 0;
    @(negedge clk);

    // Reset
    tick(1'b1, 1'b1, 1'b1, 1'b1, 16'h0BAD, 1'b1, 16'hFFFF);
    chk1("rst_req", seenReq, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk16("rst_pc", pc, 16'h0000);
    chk1("rst_valid", ifIdValid, 1'b0);
    chk16("rst_instr", ifIdInstr, 16'h0000);
    chk1("rst_hlt", hlt, 1'b0);

    // Straight-line fetch, latency 1
    idle();
    chk1("s1_req0", seenReq, 1'b1);
    chk16("s1_addr0", seenAddr, 16'h0000);
    ret(16'h1234);
    chk16("s1_instr0", ifIdInstr, 16'h1234);
    chk16("s1_pcinc0", ifIdPcInc, 16'h0002);
    chk1("s1_valid0", ifIdValid, 1'b1);
    idle();
    chk1("s1_req1", seenReq, 1'b1);
    chk16("s1_addr1", seenAddr, 16'h0002);
    ret(16'h5678);
    chk16("s1_instr1", ifIdInstr, 16'h5678);
    chk16("s1_pcinc1", ifIdPcInc, 16'h0004);

    // Stall on return: 3 stalled cycles starting with the returning word
    idle();
    tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'hA00B);
    chk16("st_pc_frz", pc, 16'h0004);
    chk16("st_instr_frz", ifIdInstr, 16'h5678);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk1("st_noreq1", seenReq, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk1("st_noreq2", seenReq, 1'b0);
    chk16("st_pc_frz2", pc, 16'h0004);
    idle();
    chk16("st_instr", ifIdInstr, 16'hA00B);
    chk16("st_pc", pc, 16'h0006);

    // Redirect while waiting; stale word must not reach decode
    idle();
    tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0);
    idle();
    ret(16'h2222);
    chk16("br_instr", ifIdInstr, 16'hA00B);
    idle();
    chk1("br_req", seenReq, 1'b1);
    chk16("br_addr", seenAddr, 16'h0100);
    ret(16'h1111);
    chk16("br_pc", pc, 16'h0102);

    // Flush coinciding with a load
    idle();
    tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h3333);
    chk1("fl_valid", ifIdValid, 1'b0);
    chk16("fl_pc", pc, 16'h0104);

    // Halt and restart
    idle();
    ret(16'hF000);
    chk1("ht_hlt", hlt, 1'b1);
    idle();
    chk1("ht_noreq", seenReq, 1'b0);
    idle();
    chk16("ht_pc", pc, 16'h0106);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0);
    chk1("ht_clr", hlt, 1'b0);
    idle();
    chk1("ht_req", seenReq, 1'b1);
    chk16("ht_addr", seenAddr, 16'h0040);

    // Reset while a request is outstanding, then a late word
    tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    ret(16'h4444);
    chk1("rw_req", seenReq, 1'b1);
    chk16("rw_addr", seenAddr, 16'h0000);
    chk16("rw_pc", pc, 16'h0000);
    chk1("rw_valid", ifIdValid, 1'b0);
    ret(16'h0001);
    chk16("rw_instr", ifIdInstr, 16'h0001);

    // PC wrap at the top of the address space
    tick(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0);
    idle();
    chk16("wr_addr", seenAddr, 16'hFFFE);
    ret(16'h5555);
    chk16("wr_pc", pc, 16'h0000);
    chk16("wr_pcinc", ifIdPcInc, 16'h0000);

    // Randomized traffic with a 1..3 cycle memory and stray valids
    pend = 0;
    for (int i = 0; i < 3000; i++) begin
      rV = (pend == 1) || ($urandom_range(0, 9) == 0);
      if (pend > 0) pend--;
      rD = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rD[15:12] = 4'hF;
      else if (rD[15:12] == 4'hF)    rD[15:12] = 4'h0;
      rR = ($urandom_range(0, 59) == 0);
      rS = ($urandom_range(0, 3) == 0);
      rF = ($urandom_range(0, 7) == 0);
      rB = ($urandom_range(0, 7) == 0);
      rT = 16'($urandom) & 16'hFFFE;
      tick(rR, rS, rF, rB, rT, rV, rD);
      if (rR)      pend = 0;
      if (seenReq) pend = $urandom_range(1, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous and active-high.
REQ-003 SHALL have port: stall  input  1  hazard hold; freeze the IF/ID register and PC advance.
REQ-004 SHALL have port: flush  input  1  squash IF/ID contents (valid to 0).
REQ-005 SHALL have ports: br_taken  input  1 and br_target  input  16; redirect the PC to br_target.
REQ-006 SHALL have ports: imem_req  output  1 and imem_addr  output  16; fetch request, one-cycle pulse.
REQ-007 SHALL have ports: imem_rdata  input  16 and imem_valid  input  1; returned instruction word, 1..N cycles after imem_req.
REQ-008 SHALL have ports: if_id_instr  output  16, if_id_pc_inc  output  16 and if_id_valid  output  1; pipeline register to decode.
REQ-009 SHALL have ports: pc  output  16 (current fetch address) and hlt  output  1 (halt reached).

Function
REQ-010 SHALL implement FSM states FETCH, WAIT, HOLD and HALTED, with exactly one state active.
REQ-011 FETCH SHALL drive imem_req=1 and imem_addr=pc, then go to WAIT, unless br_taken=1 that cycle.
REQ-012 FETCH with br_taken=1 SHALL drive imem_req=0, load pc<=br_target, and stay in FETCH.
REQ-013 WAIT SHALL hold imem_req=0; while imem_valid=0 it SHALL remain in WAIT with the PC unchanged.
REQ-014 WAIT with br_taken=1 and imem_valid=0 SHALL set a discard flag and load pc<=br_target.
REQ-015 WAIT with imem_valid=1 and either the discard flag set or br_taken=1 SHALL:
- drop the returned word;
- clear the discard flag;
- load pc<=br_target if br_taken=1;
- go to FETCH.
REQ-016 WAIT with an accepted imem_valid=1 and stall=0 SHALL, on the same edge:
- load if_id_instr<=imem_rdata, if_id_pc_inc<=pc+2 and if_id_valid<=1;
- advance pc<=pc+2.
REQ-017 WAIT with an accepted imem_valid=1 and stall=1 SHALL latch imem_rdata into a one-entry hold buffer and go to HOLD.
REQ-018 HOLD SHALL keep pc and the IF/ID register unchanged while stall=1.
REQ-019 HOLD with stall=0 SHALL load IF/ID from the hold buffer and advance pc by 2.
REQ-020 HOLD with br_taken=1 SHALL discard the buffer, load pc<=br_target, and go to FETCH; br_taken has priority over stall.
REQ-021 A word loaded into IF/ID with opcode [15:12]=4'hF SHALL send the FSM to HALTED instead of FETCH.
REQ-022 HALTED SHALL drive hlt=1 and imem_req=0, and SHALL hold pc.
REQ-023 HALTED with br_taken=1 SHALL clear hlt, load pc<=br_target, and go to FETCH.
REQ-024 flush=1 SHALL set if_id_valid<=0 on the next edge.
REQ-025 flush SHALL override any simultaneous IF/ID load; the PC still advances as if the load occurred.
REQ-026 stall=1 without flush SHALL hold if_id_instr, if_id_pc_inc and if_id_valid unchanged.
REQ-027 PC arithmetic SHALL be 16-bit modulo; 0xFFFE+2 SHALL wrap to 0x0000 with no flag.
REQ-028 imem_valid arriving in FETCH, HOLD or HALTED SHALL be ignored.

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL:
- set pc=0x0000, state=FETCH, if_id_valid=0, if_id_instr=0x0000 and if_id_pc_inc=0x0000;
- set hlt=0 and clear the discard flag and hold buffer.
REQ-030 imem_req SHALL be 0 in any cycle where rst=1.
REQ-031 rst SHALL override stall, flush, br_taken and imem_valid.
REQ-032 rst asserted while in WAIT SHALL abandon the outstanding request; a late imem_valid SHALL be ignored per REQ-028.

Verification
REQ-033 Bench SHALL cover straight-line fetch:
- stimulus: memory latency 1, words 0x1234 then 0x5678;
- response: imem_req pulses at pc 0x0000 then 0x0002;
- response: IF/ID shows 0x1234 with pc_inc 0x0002, then 0x5678 with pc_inc 0x0004.
REQ-034 Bench SHALL cover stall on return:
- stimulus: stall=1 for 3 cycles, starting on the cycle imem_valid returns 0xA00B;
- response: IF/ID and pc are frozen, with no new imem_req;
- response: after stall falls, if_id_instr=0xA00B and pc advances by 2.
REQ-035 Bench SHALL cover redirect in WAIT:
- stimulus: br_taken=1, br_target=0x0100, two cycles before imem_valid returns 0x2222;
- response: 0x2222 never reaches IF/ID;
- response: the next imem_addr is 0x0100.
REQ-036 Bench SHALL cover flush with load:
- stimulus: flush=1 on the cycle imem_valid returns 0x3333;
- response: if_id_valid=0 and pc advances by 2.
REQ-037 Bench SHALL cover halt:
- stimulus: fetched word 0xF000;
- response: hlt=1 and no further imem_req;
- response: after a later br_taken to 0x0040, hlt=0 and imem_addr=0x0040.
REQ-038 Bench SHALL cover reset mid-WAIT:
- stimulus: rst=1 for 1 cycle while WAIT is outstanding, then imem_valid=1;
- response: pc=0x0000, if_id_valid=0, and the late word is dropped;
- response: a fresh imem_req is issued at 0x0000.
